// File: rtl/a23_mem_write_splitter.sv
// Splits multi-lane core stores into consecutive single-byte memory writes.
// Optional illegal-region write check enabled by defining A23_WSPLIT_ERR_EN.
module a23_mem_write_splitter #(
    parameter int SPLIT_FULL_WORD = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic        i_write_en,
    input  logic [3:0]  i_byte_enable,
    output logic        o_stall,
    output logic [31:0] o_read_data,
    output logic [31:0] o_m_address,
    output logic [31:0] o_m_write,
    output logic        o_m_write_en,
    output logic [3:0]  o_m_byte_enable,
`ifdef A23_WSPLIT_ERR_EN
    output logic        o_err,
`endif
    input  logic [31:0] i_m_read
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SPLIT = 1'b1;

    logic        state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  core_low, split_low;
    logic        is_onehot, is_single;
    logic        illegal;

    function automatic logic [3:0] lowest_lane(input logic [3:0] m);
        return m & (~m + 4'd1);
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] d, input logic [3:0] oh);
        case (oh)
            4'b0001: return d[7:0];
            4'b0010: return d[15:8];
            4'b0100: return d[23:16];
            4'b1000: return d[31:24];
            default: return 8'h00;
        endcase
    endfunction

    assign o_read_data = i_m_read;
    assign core_low    = lowest_lane(i_byte_enable);
    assign split_low   = lowest_lane(mask_q);
    assign is_onehot   = (i_byte_enable != 4'b0000) && ((i_byte_enable & (i_byte_enable - 4'd1)) == 4'b0000);
    assign is_single   = is_onehot || ((i_byte_enable == 4'b1111) && (SPLIT_FULL_WORD == 0));

`ifdef A23_WSPLIT_ERR_EN
    logic err_q;

    assign illegal = (i_address[31:24] == 8'h01) || (i_address[31:24] == 8'h02) ||
                     (i_address[31:24] >= 8'h05);
    assign o_err   = err_q & ~i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            err_q <= 1'b0;
        else if ((state_q == ST_IDLE) && i_write_en && illegal)
            err_q <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        data_d          = data_q;
        mask_d          = mask_q;
        o_m_address     = i_address;
        o_m_write       = i_write_data;
        o_m_write_en    = i_write_en;
        o_m_byte_enable = i_byte_enable;
        o_stall         = 1'b0;

        if (state_q == ST_SPLIT) begin
            o_m_address     = addr_q;
            o_m_write       = {24'h0, lane_byte(data_q, split_low)};
            o_m_write_en    = 1'b1;
            o_m_byte_enable = split_low;
            mask_d          = mask_q & ~split_low;
            o_stall         = (mask_d != 4'b0000);
            if (mask_d == 4'b0000)
                state_d = ST_IDLE;
        end else if (i_write_en) begin
            if (illegal || (i_byte_enable == 4'b0000)) begin
                o_m_write_en = 1'b0;
            end else if (is_single) begin
                if (is_onehot)
                    o_m_write = {24'h0, lane_byte(i_write_data, i_byte_enable)};
            end else begin
                // First lane goes out now; the rest are replayed from latched copies.
                o_m_write       = {24'h0, lane_byte(i_write_data, core_low)};
                o_m_byte_enable = core_low;
                o_stall         = 1'b1;
                addr_d          = i_address;
                data_d          = i_write_data;
                mask_d          = i_byte_enable & ~core_low;
                state_d         = ST_SPLIT;
            end
        end

        if (i_rst) begin
            o_m_write_en = 1'b0;
            o_stall      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_a23_mem_write_splitter.sv
// Directed bench for a23_mem_write_splitter; dut0 uses SPLIT_FULL_WORD=0, dut1 uses 1.
module tb_a23_mem_write_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, mread;
    logic        we;
    logic [3:0]  be;

    logic        st0, st1, we0, we1;
    logic [31:0] rd0, rd1, ma0, ma1, mw0, mw1;
    logic [3:0]  be0, be1;
`ifdef A23_WSPLIT_ERR_EN
    logic        err0, err1;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    a23_mem_write_splitter #(.SPLIT_FULL_WORD(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_address(addr), .i_write_data(wdata),
        .i_write_en(we), .i_byte_enable(be), .o_stall(st0), .o_read_data(rd0),
        .o_m_address(ma0), .o_m_write(mw0), .o_m_write_en(we0), .o_m_byte_enable(be0),
`ifdef A23_WSPLIT_ERR_EN
        .o_err(err0),
`endif
        .i_m_read(mread)
    );

    a23_mem_write_splitter #(.SPLIT_FULL_WORD(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_address(addr), .i_write_data(wdata),
        .i_write_en(we), .i_byte_enable(be), .o_stall(st1), .o_read_data(rd1),
        .o_m_address(ma1), .o_m_write(mw1), .o_m_write_en(we1), .o_m_byte_enable(be1),
`ifdef A23_WSPLIT_ERR_EN
        .o_err(err1),
`endif
        .i_m_read(mread)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        we = w; addr = a; wdata = d; be = b;
        #1;
    endtask

    initial begin
        rst = 1'b1; mread = 32'h12345678;
        drive(1'b1, 32'h03000000, 32'hAABBCCDD, 4'b1111);
        check("rst_we0", we0, 0);
        check("rst_we1", we1, 0);
        check("rst_st0", st0, 0);
        check("rst_st1", st1, 0);
        check("rst_rd0", rd0, 32'h12345678);
        tick(); tick();
        rst = 1'b0;
        #1;

        // full word: single cycle on dut0, four lanes on dut1
        check("fw_we0", we0, 1);
        check("fw_be0", be0, 4'b1111);
        check("fw_wr0", mw0, 32'hAABBCCDD);
        check("fw_st0", st0, 0);
        check("fw_ad0", ma0, 32'h03000000);
        check("fw1_l0_be", be1, 4'b0001);
        check("fw1_l0_wr", mw1, 32'h000000DD);
        check("fw1_l0_st", st1, 1);
        tick();
        check("fw1_l1_be", be1, 4'b0010);
        check("fw1_l1_wr", mw1, 32'h000000CC);
        check("fw1_l1_st", st1, 1);
        check("fw1_l1_ad", ma1, 32'h03000000);
        tick();
        check("fw1_l2_wr", mw1, 32'h000000BB);
        check("fw1_l2_st", st1, 1);
        tick();
        check("fw1_l3_be", be1, 4'b1000);
        check("fw1_l3_wr", mw1, 32'h000000AA);
        check("fw1_l3_st", st1, 0);
        check("fw1_l3_we", we1, 1);
        check("fw1_l3_ad", ma1, 32'h03000000);
        tick();

        // halfword split followed back-to-back by a three-lane split
        drive(1'b1, 32'h04000010, 32'h11223344, 4'b1100);
        check("hw_c0_be", be0, 4'b0100);
        check("hw_c0_wr", mw0, 32'h00000022);
        check("hw_c0_st", st0, 1);
        check("hw_c0_ad", ma0, 32'h04000010);
        check("hw_c0_we", we0, 1);
        tick();
        check("hw_c1_be", be0, 4'b1000);
        check("hw_c1_wr", mw0, 32'h00000011);
        check("hw_c1_st", st0, 0);
        check("hw_c1_ad", ma0, 32'h04000010);
        tick();
        drive(1'b1, 32'h00000020, 32'h44332211, 4'b1011);
        check("tl_c0_be", be0, 4'b0001);
        check("tl_c0_wr", mw0, 32'h00000011);
        check("tl_c0_st", st0, 1);
        tick();
        check("tl_c1_be", be0, 4'b0010);
        check("tl_c1_wr", mw0, 32'h00000022);
        check("tl_c1_st", st0, 1);
        check("tl_c1_ad", ma0, 32'h00000020);
        tick();
        check("tl_c2_be", be0, 4'b1000);
        check("tl_c2_wr", mw0, 32'h00000044);
        check("tl_c2_st", st0, 0);
        tick();

        // one-hot single write
        drive(1'b1, 32'h00000100, 32'hA1B2C3D4, 4'b0100);
        check("oh_we0", we0, 1);
        check("oh_wr0", mw0, 32'h000000B2);
        check("oh_be0", be0, 4'b0100);
        check("oh_st0", st0, 0);
        check("oh_wr1", mw1, 32'h000000B2);
        check("oh_st1", st1, 0);
        tick();

        // zero mask and read
        drive(1'b1, 32'h00000000, 32'hFFFFFFFF, 4'b0000);
        check("zm_we0", we0, 0);
        check("zm_we1", we1, 0);
        check("zm_st0", st0, 0);
        tick();
        mread = 32'hDEADBEEF;
        drive(1'b0, 32'h01000004, 32'h0, 4'b0000);
        check("rd_rd0", rd0, 32'hDEADBEEF);
        check("rd_rd1", rd1, 32'hDEADBEEF);
        check("rd_st0", st0, 0);
        check("rd_ad0", ma0, 32'h01000004);
        check("rd_we0", we0, 0);
        tick();

        // reset in the middle of a dut1 full-word split
        drive(1'b1, 32'h00000040, 32'h55667788, 4'b1111);
        check("rm_l0_wr", mw1, 32'h00000088);
        check("rm_l0_st", st1, 1);
        tick();
        rst = 1'b1;
        #1;
        check("rm_rst_we", we1, 0);
        check("rm_rst_st", st1, 0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h00000080, 32'h000000EE, 4'b0001);
        check("rm_pt_we", we1, 1);
        check("rm_pt_wr", mw1, 32'h000000EE);
        check("rm_pt_be", be1, 4'b0001);
        check("rm_pt_ad", ma1, 32'h00000080);
        check("rm_pt_st", st1, 0);
        tick();
        drive(1'b0, 32'h00000084, 32'h0, 4'b0000);
        check("rm_idle_we", we1, 0);
        check("rm_idle_st", st1, 0);
        tick();

`ifdef A23_WSPLIT_ERR_EN
        drive(1'b1, 32'h02000000, 32'hCAFEF00D, 4'b1111);
        check("er_we0", we0, 0);
        check("er_we1", we1, 0);
        check("er_st1", st1, 0);
        check("er_pre0", err0, 0);
        tick();
        drive(1'b1, 32'h00000000, 32'h00000001, 4'b0001);
        check("er_set0", err0, 1);
        check("er_set1", err1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("er_sticky", err0, 1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h00000000, 32'h0, 4'b0000);
        check("er_clr0", err0, 0);
        check("er_clr1", err1, 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/a23_mem_write_splitter.md
A23_MEM_WRITE_SPLITTER -- requirements
Module: a23_mem_write_splitter

Interface
REQ-001 SHALL have parameter SPLIT_FULL_WORD, default 0; when 1, byte_enable 4'b1111 writes are also split into four single-byte writes.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port i_address, input, 32, core word address; [31:24] selects the region.
REQ-005 SHALL have port i_write_data, input, 32, core store data, byte lane k in bits [8k+7:8k].
REQ-006 SHALL have port i_write_en, input, 1, core store request.
REQ-007 SHALL have port i_byte_enable, input, 4, core lane mask, any value.
REQ-008 SHALL have port o_stall, output, 1, core holds all inputs while high.
REQ-009 SHALL have port o_read_data, output, 32, equal to i_m_read at all times.
REQ-010 SHALL have ports o_m_address (out, 32), o_m_write (out, 32), o_m_write_en (out, 1) and o_m_byte_enable (out, 4), which drive the memory.
REQ-011 SHALL have port i_m_read, input, 32, the combinational memory read data.
REQ-012 SHALL have port o_err, output, 1, the sticky illegal-write flag; present only with A23_WSPLIT_ERR_EN.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SPLIT.
REQ-014 In IDLE, with no write or a legal single write, SHALL pass through address, data, write_en and byte_enable combinationally and hold o_stall=0.
REQ-015 Legal single write SHALL be byte_enable 4'b1111 (when SPLIT_FULL_WORD=0) or one-hot.
REQ-016 A one-hot lane-k write SHALL drive o_m_write[7:0] = i_write_data[8k+7:8k], upper bits 0, and o_m_byte_enable one-hot k.
REQ-017 A write with byte_enable 4'b0000 SHALL drive o_m_write_en=0, o_stall=0 and complete in 0 extra cycles.
REQ-018 Any other write mask (2 or 3 lanes set, or 1111 with SPLIT_FULL_WORD=1) SHALL be a split write.
REQ-019 In IDLE, a split write SHALL, in the same cycle, issue the lowest set lane, assert o_stall=1, and latch the address, the data and the remaining mask; next state is SPLIT.
REQ-020 In SPLIT, each cycle SHALL issue the lowest remaining lane from the latched copies and clear it from the mask; core inputs are ignored.
REQ-021 In SPLIT, o_stall SHALL be 1 except in the cycle issuing the last lane, where it is 0; next state is IDLE.
REQ-022 An N-lane split SHALL take exactly N cycles, with o_stall high for N-1 cycles.
REQ-023 o_m_address SHALL be identical, the unmodified base address, for every byte write of a split.
REQ-024 Reads (i_write_en=0) SHALL never stall; during SPLIT the memory address is the latched store address.
REQ-025 Back-to-back split writes SHALL be accepted in the IDLE cycle immediately following the last lane, with no bubble.

Reset
REQ-026 While i_rst=1, SHALL force o_m_write_en=0, o_stall=0 and o_err=0.
REQ-027 On the edge where i_rst=1, SHALL set state to IDLE and clear the latched mask, address and data to 0.
REQ-028 Reset during SPLIT SHALL abandon the remaining lanes; no further lane is issued after reset deasserts.

Configuration
REQ-029 Macro A23_WSPLIT_ERR_EN SHALL control the illegal-write check.
REQ-030 When A23_WSPLIT_ERR_EN is defined, a write to region 8'h01, 8'h02 or 8'h05..8'hFF SHALL set o_err=1 on the next edge, sticky until reset.
REQ-031 When A23_WSPLIT_ERR_EN is defined, a flagged write SHALL be suppressed, with o_m_write_en=0 and no split.
REQ-032 When A23_WSPLIT_ERR_EN is undefined, port o_err SHALL be absent, all writes SHALL be forwarded unchanged, and there SHALL be no extra state.

Verification
REQ-033 Full word: addr 0x03000000, data 0xAABBCCDD, be 1111 -> one cycle, o_m_byte_enable 1111, o_m_write 0xAABBCCDD, o_stall 0.
REQ-034 Halfword: addr 0x04000010, data 0x1122_3344, be 1100 -> cycle0 lane2 o_m_write 0x00000022, stall 1; cycle1 lane3 0x00000011, stall 0; then IDLE.
REQ-035 Three lanes: be 1011, data 0x44332211 -> lane0 0x11, lane1 0x22, lane3 0x44 on three consecutive cycles; stall pattern 1,1,0.
REQ-036 Reset mid-split: be 1111 with SPLIT_FULL_WORD=1, i_rst high on cycle 1 -> only lane0 written; next cycle IDLE, stall 0, pass-through resumes.
REQ-037 Zero mask and read: write be 0000 -> o_m_write_en 0; read at 0x01000004 -> o_read_data equals i_m_read the same cycle, o_stall 0.
REQ-038 A23_WSPLIT_ERR_EN defined: write to 0x02000000 -> o_m_write_en 0, o_err 1 the next cycle, still 1 after 5 further legal writes, 0 after reset.
